conv_out_requant: RTL and testbench



---
 rtl/npu_pkg.sv | 68 ++++++
 rtl/requant_stage_reg.sv | 28 ++
 rtl/conv_out_requant.sv | 166 ++++++++++++++++
 tb/tb_conv_out_requant.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU definitions: datapath widths, int8 saturation bounds, the latched
// requantization config and the per-stage payloads of the requant pipeline.
package npu_pkg;

   localparam int NPU_IN_WIDTH           = 16;
   localparam int NPU_OUT_WIDTH          = 8;
   localparam int NPU_MULT_WIDTH         = 16;
   localparam int NPU_SHIFT_WIDTH        = 5;
   localparam int NPU_ADDR_WIDTH         = 18;
   localparam int NPU_NUM_CHANNELS_WIDTH = 7;

   localparam int PROD_WIDTH = NPU_IN_WIDTH + NPU_MULT_WIDTH;
   localparam int SUM_WIDTH  = PROD_WIDTH + 1;
   localparam int OFS_WIDTH  = PROD_WIDTH + 2;

   localparam int INT8_MIN = -128;
   localparam int INT8_MAX = 127;

   typedef struct packed {
      logic signed [NPU_MULT_WIDTH-1:0] mult;
      logic [NPU_SHIFT_WIDTH-1:0]       shift;
      logic signed [NPU_OUT_WIDTH-1:0]  zero_point;
      logic                             relu_en;
      logic [2*NPU_ADDR_WIDTH-1:0]      frame_len;
   } requant_cfg_t;

   // Each beat carries the config fields later stages need, so two frames
   // with different configs can share the pipeline without interference.
   typedef struct packed {
      logic signed [PROD_WIDTH-1:0]        prod;
      logic [NPU_SHIFT_WIDTH-1:0]          shift;
      logic signed [NPU_OUT_WIDTH-1:0]     zero_point;
      logic                                relu_en;
      logic                                last;
      logic [NPU_NUM_CHANNELS_WIDTH-1:0]   user;
   } s1_pay_t;

   typedef struct packed {
      logic signed [OFS_WIDTH-1:0]         value;
      logic signed [NPU_OUT_WIDTH-1:0]     zero_point;
      logic                                relu_en;
      logic                                last;
      logic [NPU_NUM_CHANNELS_WIDTH-1:0]   user;
   } s2_pay_t;

   typedef struct packed {
      logic [NPU_OUT_WIDTH-1:0]            data;
      logic                                last;
      logic [NPU_NUM_CHANNELS_WIDTH-1:0]   user;
   } s3_pay_t;

   // Round-half-up arithmetic right shift; shift == 0 passes the product through.
   function automatic logic signed [SUM_WIDTH-1:0] round_shift(
      input logic signed [PROD_WIDTH-1:0] prod,
      input logic [NPU_SHIFT_WIDTH-1:0]   shift
   );
      logic signed [SUM_WIDTH-1:0] wide;
      logic signed [SUM_WIDTH-1:0] bias;
      wide        = SUM_WIDTH'(prod);
      bias        = '0;
      round_shift = wide;
      if (shift != '0) begin
         bias        = SUM_WIDTH'(1) <<< (shift - NPU_SHIFT_WIDTH'(1));
         round_shift = (wide + bias) >>> shift;
      end
   endfunction

endpackage

// File: rtl/requant_stage_reg.sv
// Generic elastic pipeline register: loads whenever it is empty or its
// downstream consumer takes the current contents in the same cycle.
module requant_stage_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready
);

   assign in_ready = !rst && (!out_valid || out_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) out_data <= in_data;
      end
   end

endmodule

// File: rtl/conv_out_requant.sv
// Requantizes signed conv results to int8: multiply, rounding shift, zero-point
// offset, optional ReLU clamp and saturation, in a 3-stage elastic pipeline.
module conv_out_requant
   import npu_pkg::*;
#(
   parameter int IN_WIDTH           = NPU_IN_WIDTH,
   parameter int OUT_WIDTH          = NPU_OUT_WIDTH,
   parameter int MULT_WIDTH         = NPU_MULT_WIDTH,
   parameter int SHIFT_WIDTH        = NPU_SHIFT_WIDTH,
   parameter int ADDR_WIDTH         = NPU_ADDR_WIDTH,
   parameter int NUM_CHANNELS_WIDTH = NPU_NUM_CHANNELS_WIDTH
) (
   input  logic                          s00_axis_aclk,
   input  logic                          s00_axis_areset,
   input  logic [IN_WIDTH-1:0]           s00_axis_tdata,
   input  logic                          s00_axis_tvalid,
   output logic                          s00_axis_tready,
   input  logic                          s00_axis_tlast,
   input  logic [NUM_CHANNELS_WIDTH-1:0] s00_axis_tuser,
   output logic [OUT_WIDTH-1:0]          m00_axis_tdata,
   output logic                          m00_axis_tvalid,
   input  logic                          m00_axis_tready,
   output logic                          m00_axis_tlast,
   output logic [NUM_CHANNELS_WIDTH-1:0] m00_axis_tuser,
   input  logic [MULT_WIDTH-1:0]         cfg_mult,
   input  logic [SHIFT_WIDTH-1:0]        cfg_shift,
   input  logic [OUT_WIDTH-1:0]          cfg_zero_point,
   input  logic                          cfg_relu_en,
   input  logic [2*ADDR_WIDTH-1:0]       cfg_frame_len,
   output logic                          len_err,
   output logic [15:0]                   sat_count
);

   // Handshake: a beat moves when valid && ready on the same edge; valid never
   // waits on ready, and a stalled output holds data/last/user unchanged.

   requant_cfg_t            cfg_q;
   requant_cfg_t            cfg_eff;
   logic [2*ADDR_WIDTH-1:0] beat_cnt;
   logic [2*ADDR_WIDTH-1:0] beat_cnt_inc;
   logic                    s_fire;

   s1_pay_t s1_in, s1_q;
   s2_pay_t s2_in, s2_q;
   s3_pay_t s3_in, s3_q;
   logic    s1_valid, s2_valid, s3_valid;
   logic    s1_ready, s2_ready, s3_ready;

   logic signed [OFS_WIDTH-1:0] clamp_lo;
   logic signed [OFS_WIDTH-1:0] clamp_hi;
   logic signed [OFS_WIDTH-1:0] clamped;
   logic                        clamp_hit;

   // The first beat of a frame uses the live config and latches it for the rest.
   always_comb begin
      cfg_eff = cfg_q;
      if (beat_cnt == '0) begin
         cfg_eff.mult       = cfg_mult;
         cfg_eff.shift      = cfg_shift;
         cfg_eff.zero_point = cfg_zero_point;
         cfg_eff.relu_en    = cfg_relu_en;
         cfg_eff.frame_len  = cfg_frame_len;
      end
   end

   assign s_fire       = s00_axis_tvalid && s00_axis_tready;
   assign beat_cnt_inc = beat_cnt + (2*ADDR_WIDTH)'(1);

   always_comb begin
      s1_in            = '0;
      s1_in.prod       = PROD_WIDTH'($signed(s00_axis_tdata)) * PROD_WIDTH'(cfg_eff.mult);
      s1_in.shift      = cfg_eff.shift;
      s1_in.zero_point = cfg_eff.zero_point;
      s1_in.relu_en    = cfg_eff.relu_en;
      s1_in.last       = s00_axis_tlast;
      s1_in.user       = s00_axis_tuser;
   end

   always_comb begin
      s2_in            = '0;
      s2_in.value      = OFS_WIDTH'(round_shift(s1_q.prod, s1_q.shift))
                       + OFS_WIDTH'(s1_q.zero_point);
      s2_in.zero_point = s1_q.zero_point;
      s2_in.relu_en    = s1_q.relu_en;
      s2_in.last       = s1_q.last;
      s2_in.user       = s1_q.user;
   end

   always_comb begin
      clamp_hi = OFS_WIDTH'(INT8_MAX);
      clamp_lo = s2_q.relu_en ? OFS_WIDTH'(s2_q.zero_point) : OFS_WIDTH'(INT8_MIN);
      clamped  = s2_q.value;
      if (s2_q.value > clamp_hi)      clamped = clamp_hi;
      else if (s2_q.value < clamp_lo) clamped = clamp_lo;
      clamp_hit  = (clamped != s2_q.value);
      s3_in      = '0;
      s3_in.data = clamped[OUT_WIDTH-1:0];
      s3_in.last = s2_q.last;
      s3_in.user = s2_q.user;
   end

   requant_stage_reg #(.W($bits(s1_pay_t))) u_stage1 (
      .clk       (s00_axis_aclk),
      .rst       (s00_axis_areset),
      .in_valid  (s00_axis_tvalid),
      .in_data   (s1_in),
      .in_ready  (s1_ready),
      .out_valid (s1_valid),
      .out_data  (s1_q),
      .out_ready (s2_ready)
   );

   requant_stage_reg #(.W($bits(s2_pay_t))) u_stage2 (
      .clk       (s00_axis_aclk),
      .rst       (s00_axis_areset),
      .in_valid  (s1_valid),
      .in_data   (s2_in),
      .in_ready  (s2_ready),
      .out_valid (s2_valid),
      .out_data  (s2_q),
      .out_ready (s3_ready)
   );

   requant_stage_reg #(.W($bits(s3_pay_t))) u_stage3 (
      .clk       (s00_axis_aclk),
      .rst       (s00_axis_areset),
      .in_valid  (s2_valid),
      .in_data   (s3_in),
      .in_ready  (s3_ready),
      .out_valid (s3_valid),
      .out_data  (s3_q),
      .out_ready (m00_axis_tready)
   );

   assign s00_axis_tready = s1_ready;
   assign m00_axis_tvalid = s3_valid;
   assign m00_axis_tdata  = s3_q.data;
   assign m00_axis_tlast  = s3_q.last;
   assign m00_axis_tuser  = s3_q.user;

   always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_areset) begin
         cfg_q     <= '0;
         beat_cnt  <= '0;
         len_err   <= 1'b0;
         sat_count <= '0;
      end else begin
         len_err <= 1'b0;
         if (s_fire) begin
            if (beat_cnt == '0) cfg_q <= cfg_eff;
            if (s00_axis_tlast) begin
               len_err  <= (beat_cnt_inc != cfg_eff.frame_len);
               beat_cnt <= '0;
            end else if (beat_cnt_inc == cfg_eff.frame_len) begin
               len_err  <= 1'b1;
               beat_cnt <= '0;
            end else begin
               beat_cnt <= beat_cnt_inc;
            end
         end
         if (s2_valid && s3_ready && clamp_hit && sat_count != 16'hFFFF)
            sat_count <= sat_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_conv_out_requant.sv
// Directed bench for conv_out_requant: hand-computed vectors, output capture
// queues and a stall-stability monitor.
module tb_conv_out_requant;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] s_tdata;
   logic        s_tvalid;
   logic        s_tready;
   logic        s_tlast;
   logic [6:0]  s_tuser;
   logic [7:0]  m_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic        m_tlast;
   logic [6:0]  m_tuser;
   logic [15:0] cfg_mult;
   logic [4:0]  cfg_shift;
   logic [7:0]  cfg_zero_point;
   logic        cfg_relu_en;
   logic [35:0] cfg_frame_len;
   logic        len_err;
   logic [15:0] sat_count;

   int n_cmp = 0;
   int n_bad = 0;
   int len_err_cycles = 0;
   int stall_errs = 0;

   logic [7:0] exp_q[$];
   logic       exp_last_q[$];
   logic [6:0] exp_user_q[$];
   logic [7:0] got_q[$];
   logic       got_last_q[$];
   logic [6:0] got_user_q[$];

   logic        held_valid = 1'b0;
   logic [16:0] held_payload = '0;

   always #5 clk = ~clk;

   conv_out_requant dut (
      .s00_axis_aclk   (clk),
      .s00_axis_areset (rst),
      .s00_axis_tdata  (s_tdata),
      .s00_axis_tvalid (s_tvalid),
      .s00_axis_tready (s_tready),
      .s00_axis_tlast  (s_tlast),
      .s00_axis_tuser  (s_tuser),
      .m00_axis_tdata  (m_tdata),
      .m00_axis_tvalid (m_tvalid),
      .m00_axis_tready (m_tready),
      .m00_axis_tlast  (m_tlast),
      .m00_axis_tuser  (m_tuser),
      .cfg_mult        (cfg_mult),
      .cfg_shift       (cfg_shift),
      .cfg_zero_point  (cfg_zero_point),
      .cfg_relu_en     (cfg_relu_en),
      .cfg_frame_len   (cfg_frame_len),
      .len_err         (len_err),
      .sat_count       (sat_count)
   );

   // Output capture, len_err pulse counting and stall-hold checking.
   always @(posedge clk) begin
      if (rst) begin
         held_valid = 1'b0;
      end else begin
         if (m_tvalid && m_tready) begin
            got_q.push_back(m_tdata);
            got_last_q.push_back(m_tlast);
            got_user_q.push_back(m_tuser);
         end
         if (len_err) len_err_cycles++;
         if (held_valid && {m_tvalid, m_tdata, m_tlast, m_tuser} != held_payload) stall_errs++;
         held_valid   = m_tvalid && !m_tready;
         held_payload = {m_tvalid, m_tdata, m_tlast, m_tuser};
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_cfg(input int mult, input int shift, input int zp, input bit relu, input int flen);
      cfg_mult       = 16'(mult);
      cfg_shift      = 5'(shift);
      cfg_zero_point = 8'(zp);
      cfg_relu_en    = relu;
      cfg_frame_len  = 36'(flen);
   endtask

   task automatic expect_beat(input int data, input bit last, input int user);
      exp_q.push_back(8'(data));
      exp_last_q.push_back(last);
      exp_user_q.push_back(7'(user));
   endtask

   // Called and returning at a negedge; valid is dropped on return so a
   // following call in the same timestep keeps the bus at full rate.
   task automatic send(input int data, input bit last, input int user);
      int t;
      s_tdata  = 16'(data);
      s_tlast  = last;
      s_tuser  = 7'(user);
      s_tvalid = 1'b1;
      t = 0;
      @(posedge clk);
      while (!s_tready && t < 200) begin
         t++;
         @(posedge clk);
      end
      if (t >= 200) chk("accept_timeout", 0, 1);
      @(negedge clk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      int t;
      logic [7:0] e, g;
      logic       el, gl;
      logic [6:0] eu, gu;
      t = 0;
      while (got_q.size() < exp_q.size() && t < 300) begin
         @(negedge clk);
         t++;
      end
      repeat (4) @(negedge clk);
      chk({tag, "_count"}, got_q.size(), exp_q.size());
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();  g = got_q.pop_front();
         el = exp_last_q.pop_front(); gl = got_last_q.pop_front();
         eu = exp_user_q.pop_front(); gu = got_user_q.pop_front();
         chk({tag, "_data"}, int'($signed(g)), int'($signed(e)));
         chk({tag, "_last"}, int'(gl), int'(el));
         chk({tag, "_user"}, int'(gu), int'(eu));
      end
      exp_q.delete(); exp_last_q.delete(); exp_user_q.delete();
      got_q.delete(); got_last_q.delete(); got_user_q.delete();
   endtask

   initial begin
      rst      = 1'b1;
      s_tdata  = '0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tuser  = '0;
      m_tready = 1'b1;
      set_cfg(0, 0, 0, 1'b0, 0);

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_tready", int'(s_tready), 0);
      chk("rst_m_valid", int'(m_tvalid), 0);
      chk("rst_m_data", int'(m_tdata), 0);
      chk("rst_m_last", int'(m_tlast), 0);
      chk("rst_m_user", int'(m_tuser), 0);
      chk("rst_len_err", int'(len_err), 0);
      chk("rst_sat_count", int'(sat_count), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_tready", int'(s_tready), 1);

      // Rounding shift: (300+2)>>>2 = 75, (-7+1)>>>1 = -3
      set_cfg(1, 2, 0, 1'b0, 1);
      expect_beat(75, 1'b1, 5);
      send(300, 1'b1, 5);
      set_cfg(1, 1, 0, 1'b0, 1);
      expect_beat(-3, 1'b1, 6);
      send(-7, 1'b1, 6);
      check_outputs("round");
      chk("round_sat_count", int'(sat_count), 0);

      // Saturation at both int8 bounds
      set_cfg(1, 0, 0, 1'b0, 1);
      expect_beat(127, 1'b1, 2);
      send(1000, 1'b1, 2);
      expect_beat(-128, 1'b1, 3);
      send(-1000, 1'b1, 3);
      check_outputs("sat");
      chk("sat_count_2", int'(sat_count), 2);

      // ReLU floor at zp = -10: -60 is raised to -10 (counted), 10 passes
      set_cfg(1, 0, -10, 1'b1, 1);
      expect_beat(-10, 1'b1, 4);
      send(-50, 1'b1, 4);
      expect_beat(10, 1'b1, 4);
      send(20, 1'b1, 4);
      check_outputs("relu");
      chk("relu_sat_count", int'(sat_count), 3);
      chk("no_len_err_yet", len_err_cycles, 0);

      // Early tlast in a 4-beat frame, then a correct 4-beat frame
      set_cfg(1, 0, 0, 1'b0, 4);
      expect_beat(1, 1'b0, 7); send(1, 1'b0, 7);
      expect_beat(2, 1'b0, 7); send(2, 1'b0, 7);
      expect_beat(3, 1'b1, 7); send(3, 1'b1, 7);
      check_outputs("len_short");
      chk("len_err_short", len_err_cycles, 1);
      for (int i = 4; i <= 7; i++) begin
         expect_beat(i, i == 7, 7);
         send(i, i == 7, 7);
      end
      check_outputs("len_ok");
      chk("len_err_ok_frame", len_err_cycles, 1);

      // Missing tlast at frame_len: error, sideband untouched, count restarts
      set_cfg(1, 0, 0, 1'b0, 2);
      expect_beat(8, 1'b0, 1); send(8, 1'b0, 1);
      expect_beat(9, 1'b0, 1); send(9, 1'b0, 1);
      expect_beat(10, 1'b0, 1); send(10, 1'b0, 1);
      expect_beat(11, 1'b1, 1); send(11, 1'b1, 1);
      check_outputs("len_long");
      chk("len_err_long", len_err_cycles, 2);

      // Backpressure: 16-beat frame with a 5-cycle output stall
      set_cfg(1, 0, 0, 1'b0, 16);
      for (int i = 0; i < 16; i++) expect_beat(i * 3 - 20, i == 15, 9);
      fork
         begin
            for (int i = 0; i < 16; i++) send(i * 3 - 20, i == 15, 9);
         end
         begin
            repeat (4) @(negedge clk);
            m_tready = 1'b0;
            repeat (5) @(negedge clk);
            m_tready = 1'b1;
         end
      join
      check_outputs("bp");
      chk("bp_stall_stable", stall_errs, 0);
      chk("bp_len_err", len_err_cycles, 2);
      chk("bp_sat_count", int'(sat_count), 3);

      // Mid-frame multiplier change applies from the next frame only
      set_cfg(2, 0, 0, 1'b0, 2);
      expect_beat(20, 1'b0, 11); send(10, 1'b0, 11);
      cfg_mult = 16'd3;
      expect_beat(20, 1'b1, 11); send(10, 1'b1, 11);
      expect_beat(30, 1'b0, 12); send(10, 1'b0, 12);
      expect_beat(30, 1'b1, 12); send(10, 1'b1, 12);
      check_outputs("cfg_latch");

      // Reset with three beats stuck in the pipeline
      m_tready = 1'b0;
      set_cfg(1, 0, 0, 1'b0, 8);
      send(1, 1'b0, 0);
      send(2, 1'b0, 0);
      send(3, 1'b0, 0);
      chk("inflight_valid", int'(m_tvalid), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_valid", int'(m_tvalid), 0);
      chk("midrst_tready", int'(s_tready), 0);
      chk("midrst_sat_count", int'(sat_count), 0);
      rst = 1'b0;
      m_tready = 1'b1;
      repeat (10) @(negedge clk);
      chk("midrst_no_output", got_q.size(), 0);

      // Beat counter was cleared: a 1-beat frame passes without error
      set_cfg(1, 0, 0, 1'b0, 1);
      expect_beat(5, 1'b1, 3);
      send(5, 1'b1, 3);
      check_outputs("post_rst");
      chk("post_rst_len_err", len_err_cycles, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
